// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, BCD digit
// type, per-digit radix table and active-low seven-segment patterns.
package lap_stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, LAP} sw_state_t;

  typedef logic [3:0] bcd_t;

  // Digit 0 is hundredths; 8 digits read HH:MM:SS.hh
  localparam bcd_t DIGIT_RADIX [8] = '{4'd10, 4'd10, 4'd10, 4'd6,
                                       4'd10, 4'd6, 4'd10, 4'd10};

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_LUT [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                          7'b0110000, 7'b0011001, 7'b0010010,
                                          7'b0000010, 7'b1111000, 7'b0000000,
                                          7'b0010000};

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input bcd_t d);
    return (d < 4'd10) ? SEG_LUT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/lap_stopwatch_seg_scan_mux.sv
// Multiplexed display driver: scan counter, digit select, optional leading
// zero blanking (LEADING_ZERO_BLANK_EN) and BCD-to-segment decode.
module seg_scan_mux
  import lap_stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  bcd_t [NUM_DIGITS-1:0]       digits_i,
  output logic [NUM_DIGITS-1:0]       anode_o,
  output logic [6:0]                  segs_o
);

  localparam int RMAX = CLK_HZ / REFRESH_HZ - 1;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  logic [RW-1:0]         rcnt_q;
  logic [IW-1:0]         idx_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [6:0]            segs_q;
  logic [NUM_DIGITS-1:0] blank;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and everything above it is zero; digits 0..2 always show
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digits_i[i] == 4'd0);
      blank[i]   = (i >= 3) && zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt_q  <= '0;
      idx_q   <= '0;
      anode_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      segs_q  <= SEG_LUT[0];
    end else begin
      anode_q <= ~(NUM_DIGITS'(1) << idx_q);
      segs_q  <= blank[idx_q] ? SEG_BLANK : seg_decode(digits_i[idx_q]);
      if (rcnt_q == RW'(RMAX)) begin
        rcnt_q <= '0;
        idx_q  <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  assign anode_o = anode_q;
  assign segs_o  = segs_q;

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch with start/pause, clear and lap freeze driving a multiplexed
// common-anode display. Optional feature macro: LEADING_ZERO_BLANK_EN.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  lap,
  input  logic                  clear,
  output logic                  running,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode_assert,
  output logic [6:0]            segs
);

  localparam int PMAX = CLK_HZ / TICK_HZ - 1;
  localparam int PW   = (PMAX > 0) ? $clog2(PMAX + 1) : 1;

  // Button bits are {clear, lap, start}
  logic [2:0] btn_q, btn_prev_q, rise;
  sw_state_t  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  bcd_t [NUM_DIGITS-1:0] digits_q, digits_d, snap_q, snap_d, disp;
  logic ovf_q, ovf_d, tick;

  assign rise    = btn_q & ~btn_prev_q;
  assign running = (state_q == RUN) || (state_q == LAP);
  assign tick    = running && (presc_q == PW'(PMAX));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise[0]) state_d = RUN;
      RUN:     if (rise[0]) state_d = PAUSED; else if (rise[1]) state_d = LAP;
      LAP:     if (rise[0]) state_d = PAUSED;
      PAUSED:  if (rise[0]) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (rise[2]) state_d = IDLE;
  end

  // Tick ripples through the digit chain in one cycle; carry out of the top is the wrap
  always_comb begin
    logic c;
    c        = tick;
    digits_d = digits_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) digits_d[i] = (digits_q[i] == DIGIT_RADIX[i] - 4'd1) ? 4'd0 : digits_q[i] + 4'd1;
      c = c && (digits_q[i] == DIGIT_RADIX[i] - 4'd1);
    end
    ovf_d   = c;
    presc_d = presc_q;
    snap_d  = snap_q;
    if (running)               presc_d = tick ? '0 : presc_q + 1'b1;
    else if (state_q == IDLE)  presc_d = '0;
    if (state_d == LAP && rise[1]) snap_d = digits_q;
    if (rise[2]) begin
      digits_d = '0;
      presc_d  = '0;
      snap_d   = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_q      <= '0;
      btn_prev_q <= '0;
      state_q    <= IDLE;
      presc_q    <= '0;
      digits_q   <= '0;
      snap_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      btn_q      <= {clear, lap, start};
      btn_prev_q <= btn_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      snap_q     <= snap_d;
      ovf_q      <= ovf_d;
    end
  end

  assign overflow = ovf_q;
  assign disp     = (state_q == LAP) ? snap_q : digits_q;

  seg_scan_mux #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_scan (
    .clock    (clock),
    .reset    (reset),
    .digits_i (disp),
    .anode_o  (anode_assert),
    .segs_o   (segs)
  );

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomised and directed bench for lap_stopwatch against an integer-count
// reference model (time held as total hundredths, digits derived by div/mod).
module tb_lap_stopwatch;

  localparam int DIV  = 10;
  localparam int RDIV = 4;
  localparam int N    = 8;
  localparam int MAXC = 36000000;
  localparam int W   [8] = '{1, 10, 100, 1000, 6000, 60000, 360000, 3600000};
  localparam int RDX [8] = '{10, 10, 10, 6, 10, 6, 10, 10};
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clock = 1'b0, reset, start, lap, clear;
  logic running, overflow;
  logic [N-1:0] anode_assert;
  logic [6:0] segs;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  lap_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .REFRESH_HZ(250), .NUM_DIGITS(N)) dut (
    .clock(clock), .reset(reset), .start(start), .lap(lap), .clear(clear),
    .running(running), .overflow(overflow), .anode_assert(anode_assert), .segs(segs));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_cnt, m_snap, m_presc, m_clk; // state: 0 idle 1 run 2 paused 3 lap
  bit m_ovf;
  bit [2:0] h1, h2;
  logic [7:0] exp_anode;
  logic [6:0] exp_segs;
  bit pre_req = 0;
  int pre_val = 0;

  function automatic logic [6:0] exp_seg_of(input int v, input int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i >= 3 && v < W[i]) return 7'h7F;
`endif
    return SEG[(v / W[i]) % RDX[i]];
  endfunction

  always @(posedge clock) begin : mdl
    int shown, idx, nst;
    bit rs, rl, rc, run, tk;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_snap = 0; m_presc = 0; m_clk = 0;
      m_ovf = 0; h1 = '0; h2 = '0;
      exp_anode = 8'hFE; exp_segs = 7'h40;
    end else begin
      if (pre_req) m_cnt = pre_val;
      shown = (m_state == 3) ? m_snap : m_cnt;
      idx = (m_clk / RDIV) % N;
      exp_anode = ~(8'd1 << idx);
      exp_segs = exp_seg_of(shown, idx);
      m_clk++;
      rs = h1[0] & ~h2[0]; rl = h1[1] & ~h2[1]; rc = h1[2] & ~h2[2];
      h2 = h1; h1 = {clear, lap, start};
      run = (m_state == 1) || (m_state == 3);
      tk = run && (m_presc == DIV - 1);
      m_ovf = 0;
      if (rc) begin
        m_state = 0; m_cnt = 0; m_snap = 0; m_presc = 0;
      end else begin
        nst = m_state;
        case (m_state)
          0: if (rs) nst = 1;
          1: if (rs) nst = 2; else if (rl) begin nst = 3; m_snap = m_cnt; end
          3: if (rs) nst = 2; else if (rl) m_snap = m_cnt;
          default: if (rs) nst = 1;
        endcase
        if (run) begin
          if (tk) begin
            m_presc = 0;
            m_ovf = (m_cnt == MAXC - 1);
            m_cnt = (m_cnt + 1) % MAXC;
          end else m_presc++;
        end else if (m_state == 0) m_presc = 0;
        m_state = nst;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("anode", anode_assert, exp_anode);
      chk("segs", segs, exp_segs);
      chk("running", running, (m_state == 1 || m_state == 3));
      chk("overflow", overflow, m_ovf);
    end
  end

  // ---------------- helpers ----------------
  logic [6:0] rd_raw [8];

  function automatic int seg2dig(input logic [6:0] s);
    if (s == 7'h7F) return 0;
    for (int k = 0; k < 10; k++) if (SEG[k] == s) return k;
    return 99;
  endfunction

  task automatic press(input bit s, input bit l, input bit c);
    @(negedge clock); start = s; lap = l; clear = c;
    @(negedge clock); start = 0; lap = 0; clear = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_cnt(input int target, input int budget);
    int g = 0;
    while (m_cnt != target && g < budget) begin @(negedge clock); g++; end
    if (m_cnt != target) chk("wait_cnt_timeout", m_cnt, target);
  endtask

  task automatic read_display(output int v);
    bit [7:0] seen = '0;
    int d [8];
    int g = 0;
    while (seen != 8'hFF && g < 64) begin
      @(negedge clock); g++;
      for (int i = 0; i < N; i++)
        if (anode_assert == ~(8'd1 << i)) begin
          seen[i] = 1; d[i] = seg2dig(segs); rd_raw[i] = segs;
        end
    end
    v = 0;
    if (seen != 8'hFF) begin chk("scan_timeout", seen, 8'hFF); v = -1; end
    else for (int i = 0; i < N; i++) v += d[i] * W[i];
  endtask

  task automatic preload(input logic [31:0] bcd, input int total);
    @(negedge clock);
    force dut.digits_q = bcd;
    pre_val = total; pre_req = 1;
    @(negedge clock);
    release dut.digits_q;
    pre_req = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v, v2, pulses;
    reset = 1; start = 0; lap = 0; clear = 0;
    @(negedge clock); chk_en = 1;
    repeat (2) @(negedge clock);
    chk("rst_running", running, 0);
    chk("rst_anode", anode_assert, 8'hFE);
    chk("rst_segs", segs, 7'h40);
    reset = 0;
    repeat (100) @(negedge clock);
    read_display(v); chk("idle_zero", v, 0);

    // run, pause, hold, resume
    press(1, 0, 0);
    repeat (1000) @(negedge clock);
    chk("run_running", running, 1);
    press(1, 0, 0);
    read_display(v);
    chk("run_1s_model", v, m_cnt);
    chk("run_1s_near", (v >= 99 && v <= 102), 1);
    repeat (500) @(negedge clock);
    read_display(v2); chk("pause_frozen", v2, v);
    press(1, 0, 0);
    repeat (200) @(negedge clock);
    press(1, 0, 0);
    read_display(v2);
    chk("resume_model", v2, m_cnt);
    chk("resume_advanced", (v2 > v), 1);

    // lap freeze and re-snapshot
    press(0, 0, 1);
    press(1, 0, 0);
    wait_cnt(50, 1000);
    press(0, 1, 0);
    read_display(v); chk("lap_50", v, 50);
    chk("lap_running", running, 1);
    wait_cnt(70, 1000);
    press(0, 1, 0);
    read_display(v); chk("lap_70", v, 70);
    press(1, 0, 0);
    chk("lap_to_paused", running, 0);

    // minute carry and full wrap
    preload(32'h00005999, 5999);
    press(1, 0, 0);
    wait_cnt(6000, 200);
    press(1, 0, 0);
    read_display(v); chk("carry_1min", v, 6000);
    preload(32'h99595999, MAXC - 1);
    press(1, 0, 0);
    pulses = 0;
    repeat (40) begin @(negedge clock); if (overflow) pulses++; end
    chk("ovf_pulses", pulses, 1);
    press(1, 0, 0);
    read_display(v);
    chk("wrap_model", v, m_cnt);
    chk("wrap_small", (v < 10), 1);

    // clear beats start; lap ignored in PAUSED
    press(1, 0, 0);
    repeat (30) @(negedge clock);
    press(1, 0, 1);
    chk("clr_prio_running", running, 0);
    read_display(v); chk("clr_prio_zero", v, 0);
    press(1, 0, 0);
    repeat (25) @(negedge clock);
    press(1, 0, 0);
    read_display(v);
    press(0, 1, 0);
    chk("paused_lap_running", running, 0);
    read_display(v2); chk("paused_lap_hold", v2, v);

    // reset mid-run
    press(0, 0, 1);
    press(1, 0, 0);
    wait_cnt(327, 4000);
    reset = 1;
    @(negedge clock);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_anode", anode_assert, 8'hFE);
    chk("mid_rst_segs", segs, 7'h40);
    chk("mid_rst_ovf", overflow, 0);
    reset = 0;
    repeat (3) @(negedge clock);
    read_display(v); chk("post_rst_zero", v, 0);

    // blanking view of 00:00:03.27
    press(1, 0, 0);
    repeat (5) @(negedge clock);
    press(1, 0, 0);
    preload(32'h00000327, 327);
    read_display(v); chk("show_327", v, 327);
    for (int i = 3; i < N; i++) chk("hi_digit_segs", rd_raw[i], exp_seg_of(327, i));
    chk("digit2_segs", rd_raw[2], 7'h30);

    // random button activity
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      start = ($urandom_range(0, 7) == 0);
      lap   = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 63) == 0);
    end
    start = 0; lap = 0; clear = 0;
    repeat (10) @(negedge clock);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
Parametrised successor to the single-mode stopwatch: a BCD time counter with start/pause toggle, clear and lap-freeze functions, driving a multiplexed common-anode seven-segment display.
- Digit count and clock rates are generic parameters.
- Sits between the debounced board buttons and the display pins in the vaje top level.

Parameters:
CLK_HZ, 100_000_000, system clock frequency.
TICK_HZ, 100, count resolution (100 gives hundredths of a second); CLK_HZ must be divisible by TICK_HZ.
REFRESH_HZ, 1000, digit scan rate; CLK_HZ must be divisible by REFRESH_HZ.
NUM_DIGITS, 8, displayed digits; legal range 4..8.

Ports:
clock  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high.
start  in  1  start/pause request, debounced level; acts on rising edge.
lap  in  1  lap request, debounced level; acts on rising edge.
clear  in  1  clear request, debounced level; acts on rising edge.
running  out  1  high in RUN and LAP.
overflow  out  1  one-cycle pulse when the count wraps.
anode_assert  out  NUM_DIGITS  digit enables, active-low, one-hot-low.
segs  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
Clock and reset:
- Single clock domain; reset is synchronous and active-high.

Inputs:
- All inputs are registered, then rising-edge detected.
- A request takes effect 2 clocks after the input rises.

Digit chain:
- Digit i (0 = least significant) has radix 10,10,10,6,10,6,10,10 for i = 0..7; only digits 0..NUM_DIGITS-1 exist.
- 8 digits give the format HH:MM:SS.hh.

Prescaler:
- Counts 0..CLK_HZ/TICK_HZ-1 only in RUN or LAP.
- Holds in PAUSED; is zeroed in IDLE.
- At terminal count, emits a tick that increments digit 0 and ripples carries in the same cycle.

Wrap:
- A tick when every digit is at radix-1 sets all digits to 0.
- Asserts overflow for 1 cycle; state stays RUN or LAP.

FSM states: IDLE, RUN, PAUSED, LAP. Transitions:
- IDLE + start -> RUN.
- RUN + start -> PAUSED.
- RUN + lap -> LAP: snapshot live count into the lap register.
- LAP + lap -> LAP: re-snapshot.
- LAP + start -> PAUSED.
- PAUSED + start -> RUN.
- PAUSED + lap -> no effect.
- Any state + clear -> IDLE: count, prescaler and snapshot zeroed.

Priority on simultaneous edges:
- clear > start > lap; the losing requests are dropped, not queued.

Display source:
- LAP shows the snapshot; all other states show the live count.

Scan:
- Scan counter advances one digit every CLK_HZ/REFRESH_HZ clocks, cycling 0..NUM_DIGITS-1 independently of FSM state.
- anode_assert and segs are registered together: the digit and its segment pattern change in the same cycle.

Segment encoding (active-low):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.

Reset values:
- State IDLE; all digits, prescaler, snapshot and scan index 0.
- running = 0, overflow = 0.
- anode_assert = all ones except bit 0 = 0.
- segs = 1000000.

Reset mid-operation:
- Identical to power-on reset; pending edge-detect registers are cleared, so no phantom edge occurs after reset.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: a displayed digit is blanked (segs = 1111111, anode still driven) when it is zero and all more-significant displayed digits are zero. Digit 2 (the units digit left of the hundredths) and digits below it are never blanked.
- Undefined: all digits always show their value.

Decomposition:
Package lap_stopwatch_pkg contains:
- FSM state enum sw_state_t (IDLE, RUN, PAUSED, LAP).
- Constant array DIGIT_RADIX[8].
- 4-bit BCD digit typedef.
- Constant array SEG_LUT[10] and constant SEG_BLANK.

Sub-module:
- One natural sub-module, seg_scan_mux: scan counter, digit select, blanking and BCD-to-segment decode.
- Its inputs are the chosen NUM_DIGITS x 4-bit display vector; its outputs are anode_assert and segs.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100, REFRESH_HZ=250, NUM_DIGITS=8, giving a tick every 10 clocks and a new digit every 4 clocks.
1. Reset held 3 clocks -> running = 0, anode_assert = 11111110, segs = 1000000; digits stay 0 for 100 clocks with no start.
2. start pulse, then 1000 clocks -> running = 1, display reads 00:00:01.00 (±1 tick); start again -> PAUSED, value frozen for 500 clocks; start -> resumes from frozen value.
3. In RUN at 00:00:00.50, lap -> display holds 00:00:00.50 while live count keeps advancing; after a further 200 clocks, lap -> display jumps to 00:00:00.70.
4. Preload by running until 00:00:59.99, then one tick -> 00:01:00.00; run to 99:59:59.99 via force, then one tick -> all zero and overflow high for exactly 1 cycle.
5. start and clear rising in the same cycle while in RUN -> IDLE, count 0, running = 0; lap in PAUSED -> no state change.
6. Reset asserted mid-RUN at 00:00:03.27 -> next cycle matches scenario 1 values. With LEADING_ZERO_BLANK_EN, a count of 00:00:03.27 blanks digits 3..7 (segs = 1111111).
